// File: rtl/bcd_arb_pkg.sv
// Shared types, widths and the BCD range check for the shared-decoder arbiter.
package bcd_arb_pkg;

  localparam int unsigned BIN_W = 4;
  localparam int unsigned BCD_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Flags a {tens, ones} result that is not a legal BCD encoding of 0..15.
  function automatic logic bcd_range_err(input logic [BCD_W-1:0] bcd);
    return (bcd[7:5] != 3'd0) ||
           (bcd[3:0] > 4'd9) ||
           (bcd[4] && (bcd[3:0] > 4'd5));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  function automatic logic [ID_W-1:0] wrap_idx(input int unsigned base, input int unsigned off);
    return ID_W'((base + off) % NUM_REQ);
  endfunction

  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = wrap_idx(32'(ptr), i);
      if (en && !found && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_decode_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared binary-to-BCD decoder and
// returns the registered, range-checked result on a valid/ready channel.
module bcd_decode_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*BIN_W-1:0] req_binary,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     dec_en,
  output logic [BIN_W-1:0]         dec_binary,
  input  logic [BCD_W-1:0]         dec_bcd,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [BCD_W-1:0]         rsp_bcd,
  output logic                     rsp_err,
  output logic                     busy
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             dec_en_q, dec_en_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [BCD_W-1:0] rsp_bcd_q, rsp_bcd_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    ptr_inc;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (state_q == IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign ptr_inc = ((32'(gnt_idx) + 32'd1) == NUM_REQ) ? '0 : ID_W'(32'(gnt_idx) + 32'd1);

  // bin_q doubles as the decoder operand; it is cleared once DECODE ends.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    bin_d       = bin_q;
    id_d        = id_q;
    dec_en_d    = dec_en_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_bcd_d   = rsp_bcd_q;
    rsp_err_d   = rsp_err_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          bin_d    = req_binary[BIN_W*32'(gnt_idx) +: BIN_W];
          id_d     = gnt_idx;
          rr_ptr_d = ptr_inc;
          dec_en_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        dec_en_d    = 1'b0;
        bin_d       = '0;
        rsp_bcd_d   = dec_bcd;
        rsp_id_d    = id_q;
        rsp_err_d   = bcd_range_err(dec_bcd);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        dec_en_d    = 1'b0;
        bin_d       = '0;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      bin_q       <= '0;
      id_q        <= '0;
      dec_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_bcd_q   <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      bin_q       <= bin_d;
      id_q        <= id_d;
      dec_en_q    <= dec_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_bcd_q   <= rsp_bcd_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready  = gnt;
  assign dec_en     = dec_en_q;
  assign dec_binary = bin_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_bcd    = rsp_bcd_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bcd_decode_arbiter.sv
// Directed and randomized bench for bcd_decode_arbiter against a transaction-level model.
module tb_bcd_decode_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = $clog2(NUM_REQ);

  logic                   clk;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*4-1:0]   req_binary;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   dec_en;
  logic [3:0]             dec_binary;
  logic [7:0]             dec_bcd;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [7:0]             rsp_bcd;
  logic                   rsp_err;
  logic                   busy;

  bcd_decode_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_binary (req_binary),
    .req_ready  (req_ready),
    .dec_en     (dec_en),
    .dec_binary (dec_binary),
    .dec_bcd    (dec_bcd),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_bcd    (rsp_bcd),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared decoder stand-in; can be forced to return a fixed (possibly illegal) code.
  logic       force_en;
  logic [7:0] force_val;
  always_comb begin
    dec_bcd = 8'hEE;
    if (force_en)    dec_bcd = force_val;
    else if (dec_en) dec_bcd = 8'(((int'(dec_binary) / 10) * 16) + (int'(dec_binary) % 10));
  end

  int checks = 0;
  int errors = 0;

  // Model: m_age = cycles since grant (0 none, 1 decoding, 2 response outstanding).
  int         m_ptr = 0;
  int         m_age = 0;
  int         m_val = 0;
  int         m_id  = 0;
  logic [7:0] m_bcd = 8'h00;

  function automatic logic [7:0] ref_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic ref_err(input logic [7:0] f);
    int hi, lo;
    hi = int'(f[7:4]);
    lo = int'(f[3:0]);
    return !(hi <= 1 && lo <= 9 && (hi * 10 + lo) <= 15);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*4-1:0] b,
                      input logic rdy, input logic r);
    int w;
    logic [NUM_REQ-1:0] exp_rdy;
    @(negedge clk);
    rst = r; req_valid = v; req_binary = b; rsp_ready = rdy;
    #1;
    w = -1;
    exp_rdy = '0;
    if (m_age == 0)
      for (int k = 0; k < int'(NUM_REQ); k++)
        if (w < 0 && v[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("dec_en", 32'(dec_en), 32'(m_age == 1));
    chk("dec_binary", 32'(dec_binary), (m_age == 1) ? 32'(m_val) : 32'd0);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_age == 2));
    chk("busy", 32'(busy), 32'(m_age != 0));
    if (m_age == 2) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_bcd", 32'(rsp_bcd), 32'(m_bcd));
      chk("rsp_err", 32'(rsp_err), 32'(ref_err(m_bcd)));
    end
    if (r) begin
      m_age = 0;
      m_ptr = 0;
    end else if (w >= 0) begin
      m_ptr = (w + 1) % NUM_REQ;
      m_val = int'(b[4*w +: 4]);
      m_id  = w;
      m_age = 1;
    end else if (m_age == 1) begin
      m_bcd = force_en ? force_val : ref_bcd(m_val);
      m_age = 2;
    end else if (m_age == 2 && rdy) begin
      m_age = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_dec_en", 32'(dec_en), 32'd0);
    chk("rst_dec_binary", 32'(dec_binary), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_bcd", 32'(rsp_bcd), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    m_age = 0;
    m_ptr = 0;
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_binary = '0; rsp_ready = 1'b0;
    force_en = 1'b0; force_val = 8'h00;
    repeat (2) @(posedge clk);
    do_reset();

    // Single request: 0xC -> 8'h12
    step(4'b0001, 16'h000C, 1'b1, 1'b0);
    idle_steps(4);

    // All four requesting continuously, values 1,7,A,F
    do_reset();
    for (int k = 0; k < 15; k++) step(4'b1111, 16'hFA71, 1'b1, 1'b0);
    idle_steps(3);

    // Backpressure on a response of 9 while others keep requesting
    step(4'b1000, 16'h9000, 1'b0, 1'b0);
    step(4'b0101, 16'h0303, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(4'b0101, 16'h0303, 1'b0, 1'b0);
    step(4'b0101, 16'h0303, 1'b1, 1'b0);
    idle_steps(8);

    // Decoder returning illegal codes, then all 16 legal inputs
    force_en = 1'b1; force_val = 8'h1A;
    step(4'b0010, 16'h00B0, 1'b1, 1'b0);
    idle_steps(3);
    force_val = 8'h20;
    step(4'b0100, 16'h0400, 1'b1, 1'b0);
    idle_steps(3);
    force_en = 1'b0;
    for (int v = 0; v < 16; v++) begin
      step(4'b0001, 16'(v), 1'b1, 1'b0);
      idle_steps(3);
    end

    // Reset while decoding, then requester 2 alone
    step(4'b0010, 16'h0050, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b1);
    idle_steps(2);
    step(4'b0100, 16'h0600, 1'b1, 1'b0);
    idle_steps(4);

    // Requester 1 pulses only while requester 0 is in RESP
    step(4'b0001, 16'h0008, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    step(4'b0010, 16'h0040, 1'b0, 1'b0);
    step(4'b0010, 16'h0040, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    idle_steps(4);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 400; k++)
      step(NUM_REQ'($urandom), (NUM_REQ*4)'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 60) == 0));
    idle_steps(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_decode_arbiter.md
Name: bcd_decode_arbiter

Overview:
- Shares one combinational 4-bit-binary-to-2-digit-BCD decoder between NUM_REQ requesters.
- Round-robin arbitration; captures the winner's 4-bit value and drives the decoder's enable and binary inputs for one cycle.
- Registers the 8-bit BCD result and returns it on a valid/ready response channel tagged with the requester id.
- Sits between the value producers (counters, status sources) and the shared decoder instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of requester id (derived; do not override)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request
req_binary  input  NUM_REQ*4  per-requester 4-bit value; slice i = [4*i+3:4*i]
req_ready  output  NUM_REQ  one-hot grant/accept; handshake = req_valid[i] & req_ready[i]
dec_en  output  1  enable to shared decoder
dec_binary  output  4  value to shared decoder
dec_bcd  input  8  decoder result ({tens, ones} BCD)
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_id  output  ID_W  index of requester that owns the response
rsp_bcd  output  8  registered BCD result
rsp_err  output  1  decoder result failed range check
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE; rr_ptr=0; all outputs 0 (req_ready=0, dec_en=0, dec_binary=0, rsp_valid=0, rsp_id=0, rsp_bcd=0, rsp_err=0, busy=0).
- FSM states: IDLE, DECODE, RESP.
- IDLE:
  - If any req_valid is high, grant the first requester with req_valid set, searching upward from rr_ptr with wrap at NUM_REQ-1 -> 0.
  - req_ready is combinational: one-hot on the winner, in IDLE only. It is 0 in every other state, and 0 in IDLE when no request is pending.
  - On the handshake, capture req_binary slice into bin_q and the winner index into id_q. Set rr_ptr = winner+1 (mod NUM_REQ). Go to DECODE.
  - If no request is pending, stay in IDLE and leave rr_ptr unchanged.
- DECODE (exactly 1 cycle):
  - dec_en=1 and dec_binary=bin_q, both driven from registers.
  - At the end of the cycle, sample dec_bcd into rsp_bcd, set rsp_id=id_q, compute rsp_err, set rsp_valid=1. Go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id, rsp_bcd and rsp_err stable until rsp_valid & rsp_ready.
  - On that cycle: rsp_valid goes 0 next cycle and state returns to IDLE.
- dec_en=0 and dec_binary=0 outside DECODE.
- Latency: handshake in cycle T -> rsp_valid high in cycle T+2. Peak throughput is one transaction per 3 cycles with rsp_ready tied high.
- rsp_err=1 if any of these hold on the sampled dec_bcd:
  - dec_bcd[7:5] != 0
  - dec_bcd[3:0] > 9
  - dec_bcd[4]=1 and dec_bcd[3:0] > 5 (value above 15)
- Requester rules:
  - A requester may deassert req_valid before being granted; it is never served.
  - Values are sampled only on the handshake cycle.
  - Multiple requests in the same cycle are resolved purely by the rotating pointer.
  - No requester waits more than NUM_REQ grants.
- Reset mid-operation: rst in any state forces IDLE next cycle with all reset values. The in-flight transaction is discarded and no response is issued. rr_ptr returns to 0.
- rsp_ready while rsp_valid=0 is ignored.

Decomposition:
- Package bcd_arb_pkg:
  - state enum {IDLE, DECODE, RESP}
  - constants BIN_W=4, BCD_W=8
  - function bcd_range_err(logic [7:0]) returning the rsp_err condition
- Sub-module rr_arbiter:
  - parameter NUM_REQ
  - inputs: req vector, ptr, enable
  - output: one-hot grant plus encoded index
  - combinational only; rr_ptr lives in the parent.

Test Plan:
- Single request: req_valid=4'b0001, req_binary[3:0]=4'hC -> req_ready=4'b0001 at T; dec_en=1, dec_binary=4'hC at T+1; rsp_valid=1, rsp_id=0, rsp_bcd=8'h12, rsp_err=0 at T+2.
- All four requesting continuously with values 1,7,A,F, rsp_ready=1 -> grant order 0,1,2,3,0; responses 8'h01, 8'h07, 8'h10, 8'h15 in that order; one grant every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid with value 9 -> rsp_valid, rsp_id and rsp_bcd=8'h09 held stable; req_ready=0 throughout; completes the cycle after rsp_ready=1.
- Error check: decoder model forced to return 8'h1A, and separately 8'h20 -> rsp_err=1 with rsp_bcd equal to the forced value; correct model -> rsp_err=0 for all 16 inputs.
- Reset mid-operation: assert rst during DECODE -> next cycle state IDLE, rsp_valid=0, dec_en=0, no response for that transaction; next request from requester 2 alone is granted normally with rr_ptr restarting at 0.
- Withdrawn request: req_valid[1] pulses high only while requester 0 is in RESP -> requester 1 never granted, no response with rsp_id=1.
